mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter and scheduler for the 8-to-1 select datapath. It shares one
//  downstream consumer between 8 requesters that use valid/ready handshakes.
//  - Chooses one requester per transfer and drives the 3-bit select code
//    (000 = requester 0 ... 111 = requester 7).
//  - Registers the selected word into a one-entry output stage.
//  - Supports an optional burst grant so one requester can keep the grant for
//    up to MAX_BURST consecutive transfers.
// PARAMETERS
//  DATA_WIDTH  32  width of each requester data word
//  MAX_BURST   1   max consecutive grants to one requester (1 = pure round-robin; legal 1..255)
// PORTS
//  clk         in   1               system clock; all logic is rising-edge
//  rst         in   1               synchronous reset, active-high
//  req_valid   in   8               bit i: requester i has a word
//  req_data    in   8*DATA_WIDTH    word i sits at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready   out  8               one-hot: word i is accepted this cycle
//  out_valid   out  1               output stage holds a word
//  out_ready   in   1               consumer accepts the word
//  out_data    out  DATA_WIDTH      registered selected word
//  out_sel     out  3               registered select code (index of the owning requester)
// BEHAVIOUR
//  - One clock and one reset: a synchronous, active-high rst sampled on the rising edge of clk.
//  - Reset values:
//      out_valid = 0, out_data = 0, out_sel = 0, state = IDLE.
//      last_sel = 7, last_vld = 0, burst_cnt = 0.
//      req_ready = 0 while rst = 1.
//  - States:
//      IDLE: output stage is empty.
//      FULL: output stage holds a word (out_valid = 1).
//  - Slot free condition: accept_en = (state == IDLE) | (state == FULL & out_ready).
//  - Grant g is computed combinationally whenever accept_en = 1 and |req_valid:
//      a) Burst continuation: if last_vld & req_valid[last_sel] & (burst_cnt < MAX_BURST-1),
//         then g = last_sel.
//      b) Otherwise: g = the first i with req_valid[i] = 1, scanning last_sel+1, last_sel+2, ...
//         modulo 8 (wraps 7 -> 0).
//  - req_ready[g] = 1 only when accept_en and a grant exist; all other bits are 0.
//    req_ready depends combinationally on req_valid and out_ready.
//    Requesters must not make req_valid depend on req_ready.
//  - On an accept (at the clock edge):
//      out_data <= word g; out_sel <= g; out_valid <= 1; state <= FULL.
//      last_sel <= g; last_vld <= 1.
//      burst_cnt <= (rule a) ? burst_cnt + 1 : 0.
//  - FULL with out_ready = 1 and no req_valid: out_valid <= 0, state <= IDLE.
//    out_data and out_sel keep their values.
//  - FULL with out_ready = 1 and a new grant: drain and refill happen in the same cycle,
//    out_valid stays 1. Throughput is 1 word per cycle.
//  - FULL with out_ready = 0: out_data, out_sel, out_valid, last_sel and burst_cnt hold;
//    req_ready = 0.
//  - Latency: a word accepted at edge N shows on out_data / out_valid after edge N (1 cycle).
//  - A requester that drops req_valid breaks its burst. Rule b then applies on the next
//    grant, starting from last_sel + 1.
//  - Reset during FULL:
//      The held word is discarded and out_valid = 0 on the next cycle.
//      Priority restarts at requester 0.
//  - No word is ever duplicated or dropped: exactly one req_ready pulse for each
//    out_valid & out_ready handshake.
// TESTING
//  T1 Reset: rst = 1 for 2 cycles with req_valid = 8'hFF
//     -> req_ready = 0 and out_valid = 0 throughout;
//     -> first grant after release goes to 0 (req_ready = 8'h01).
//  T2 MAX_BURST = 1, req_valid = 8'hFF, out_ready = 1, req_data[i] = 32'hA0+i
//     -> out_sel = 0,1,...,7,0 on consecutive cycles, out_data = 32'hA0+out_sel.
//  T3 Backpressure: out_ready = 0 for 5 cycles while FULL (out_sel = 3)
//     -> out_sel and out_data stable, req_ready = 0;
//     -> raise out_ready -> next grant = 4.
//  T4 MAX_BURST = 3, req_valid = 8'h24 constant, out_ready = 1
//     -> out_sel = 2,2,2,5,5,5,2,2,2.
//  T5 Single requester 6 pulses valid for 1 cycle
//     -> req_ready = 8'h40 that cycle, out_valid = 1 for one cycle, then IDLE with out_valid = 0.
//  T6 rst = 1 while out_valid = 1, out_sel = 5
//     -> out_valid = 0 next cycle;
//     -> with req_valid = 8'h21 after release, the grant goes to 0 (not 0 via the wrap from 5).

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - 8-way round-robin arbiter with optional burst grant and one-entry output stage
module mux8_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              req_valid,
    input  logic [8*DATA_WIDTH-1:0] req_data,
    output logic [7:0]              req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [2:0]              out_sel
);

    typedef enum logic {IDLE, FULL} state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

    state_t     state;
    logic [2:0] last_sel;
    logic       last_vld;
    logic [7:0] burst_cnt;

    logic       accept_en;
    logic       accept;
    logic       grant_found;
    logic       burst_hit;
    logic [2:0] grant_idx;
    logic [2:0] cand;

    assign accept_en = (state == IDLE) || ((state == FULL) && out_ready);

    // Burst continuation wins; otherwise scan forward from the requester after the last owner.
    always_comb begin
        grant_found = 1'b0;
        burst_hit   = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        if (last_vld && req_valid[last_sel] && (burst_cnt < BURST_LIM)) begin
            grant_found = 1'b1;
            burst_hit   = 1'b1;
            grant_idx   = last_sel;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                cand = last_sel + 3'(k);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign accept    = !rst && accept_en && grant_found;
    assign req_ready = accept ? (8'b1 << grant_idx) : 8'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            last_sel  <= 3'd7;
            last_vld  <= 1'b0;
            burst_cnt <= 8'd0;
        end else if (accept) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            out_sel   <= grant_idx;
            last_sel  <= grant_idx;
            last_vld  <= 1'b1;
            burst_cnt <= burst_hit ? burst_cnt + 8'd1 : 8'd0;
        end else if ((state == FULL) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - scoreboard bench for mux8_rr_arbiter (burst 1 and burst 3 instances)
module tb_mux8_rr_arbiter;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic [255:0] req_data;

    logic         rst1, ordy1, ov1;
    logic [7:0]   rv1, rr1;
    logic [31:0]  data1;
    logic [2:0]   sel1;

    logic         rst3, ordy3, ov3;
    logic [7:0]   rv3, rr3;
    logic [31:0]  data3;
    logic [2:0]   sel3;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.DATA_WIDTH(32), .MAX_BURST(1)) u1 (
        .clk(clk), .rst(rst1), .req_valid(rv1), .req_data(req_data), .req_ready(rr1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(data1), .out_sel(sel1)
    );

    mux8_rr_arbiter #(.DATA_WIDTH(32), .MAX_BURST(3)) u3 (
        .clk(clk), .rst(rst3), .req_valid(rv3), .req_data(req_data), .req_ready(rr3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(data3), .out_sel(sel3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int s);
        exp_t e;
        e.sel  = 3'(s);
        e.data = 32'hA0 + 32'(s);
        return e;
    endfunction

    // Monitor: every output handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (ov1 && ordy1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u1_unexpected_word actual_sel=%0d required=none", sel1);
            end else begin
                e1 = q1.pop_front();
                chk("u1_out_sel", 32'(sel1), 32'(e1.sel));
                chk("u1_out_data", data1, e1.data);
            end
        end
        if (ov3 && ordy3) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u3_unexpected_word actual_sel=%0d required=none", sel3);
            end else begin
                e3 = q3.pop_front();
                chk("u3_out_sel", 32'(sel3), 32'(e3.sel));
                chk("u3_out_data", data3, e3.data);
            end
        end
    end

    int t4_seq[9] = '{2, 2, 2, 5, 5, 5, 2, 2, 2};

    initial begin
        for (int i = 0; i < 8; i++) req_data[i*32 +: 32] = 32'hA0 + 32'(i);
        rst1 = 1'b1; rv1 = 8'hFF; ordy1 = 1'b1;
        rst3 = 1'b1; rv3 = 8'h00; ordy3 = 1'b1;

        // T1: reset with all requesters active
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t1_req_ready_in_reset", 32'(rr1), 32'h0);
            chk("t1_out_valid_in_reset", 32'(ov1), 32'h0);
            nxt();
        end
        rst1 = 1'b0;

        // T2: pure round-robin sweep 0..7 then wrap to 0
        for (int i = 0; i < 9; i++) begin
            rv1 = 8'hFF; ordy1 = 1'b1;
            q1.push_back(mk(i % 8));
            @(negedge clk);
            chk("t2_req_ready", 32'(rr1), 32'(8'b1 << (i % 8)));
            nxt();
        end

        // T3: advance to owner 3, then backpressure
        for (int i = 1; i <= 3; i++) begin
            q1.push_back(mk(i));
            @(negedge clk);
            chk("t3_req_ready_fill", 32'(rr1), 32'(8'b1 << i));
            nxt();
        end
        ordy1 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_hold_req_ready", 32'(rr1), 32'h0);
            chk("t3_hold_out_sel", 32'(sel1), 32'd3);
            chk("t3_hold_out_data", data1, 32'hA3);
            chk("t3_hold_out_valid", 32'(ov1), 32'h1);
            nxt();
        end
        ordy1 = 1'b1;
        q1.push_back(mk(4));
        @(negedge clk);
        chk("t3_release_grant", 32'(rr1), 32'h10);
        nxt();

        // T5: drain, then single-cycle pulse from requester 6
        rv1 = 8'h00;
        @(negedge clk);
        chk("t5_drain_req_ready", 32'(rr1), 32'h0);
        nxt();
        rv1 = 8'h40;
        q1.push_back(mk(6));
        @(negedge clk);
        chk("t5_pulse_req_ready", 32'(rr1), 32'h40);
        nxt();
        rv1 = 8'h00;
        @(negedge clk);
        chk("t5_out_valid_one", 32'(ov1), 32'h1);
        nxt();
        @(negedge clk);
        chk("t5_idle_out_valid", 32'(ov1), 32'h0);
        chk("t5_idle_req_ready", 32'(rr1), 32'h0);
        nxt();

        // T6: reset while holding requester 5's word (that word is discarded)
        rv1 = 8'h20; ordy1 = 1'b0;
        @(negedge clk);
        chk("t6_fill_req_ready", 32'(rr1), 32'h20);
        nxt();
        rv1 = 8'h00;
        @(negedge clk);
        chk("t6_full_out_sel", 32'(sel1), 32'd5);
        chk("t6_full_out_valid", 32'(ov1), 32'h1);
        nxt();
        rst1 = 1'b1; rv1 = 8'h21;
        @(negedge clk);
        chk("t6_req_ready_in_reset", 32'(rr1), 32'h0);
        nxt();
        rst1 = 1'b0; ordy1 = 1'b1;
        q1.push_back(mk(0));
        @(negedge clk);
        chk("t6_out_valid_after_reset", 32'(ov1), 32'h0);
        chk("t6_first_grant", 32'(rr1), 32'h01);
        nxt();
        q1.push_back(mk(5));
        @(negedge clk);
        chk("t6_second_grant", 32'(rr1), 32'h20);
        nxt();
        rv1 = 8'h00;
        nxt();
        nxt();

        // T4: burst of 3 alternating between requesters 2 and 5
        rst3 = 1'b0; rv3 = 8'h24; ordy3 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            q3.push_back(mk(t4_seq[i]));
            @(negedge clk);
            chk("t4_req_ready", 32'(rr3), 32'(8'b1 << t4_seq[i]));
            nxt();
        end
        rv3 = 8'h00;
        nxt();
        nxt();

        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q3_empty", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
